// File: rtl/elastic_pipe.sv
// Elastic pipeline register chain with valid/ready handshake, synchronous flush and
// an occupancy count. Each of P_DEPTH stages holds one word. A stage advances when it
// is empty or when its downstream neighbour advances.
// Optional macro ELASTIC_PIPE_SKID_EN adds a one-entry input skid buffer. The buffer
// registers in_ready and raises capacity to P_DEPTH+1.
module elastic_pipe #(
  parameter int unsigned P_NBITS = 32,
  parameter int unsigned P_DEPTH = 2,
  parameter int unsigned P_CNTW  = $clog2(P_DEPTH + 2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [P_NBITS-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [P_NBITS-1:0] out_data,
  output logic [P_CNTW-1:0]  count
);

  logic [P_DEPTH-1:0] v_q, v_d;
  logic [P_NBITS-1:0] d_q [P_DEPTH];
  logic [P_NBITS-1:0] d_d [P_DEPTH];
  logic [P_CNTW-1:0]  count_q, count_d;
  logic [P_DEPTH-1:0] rdy;
  logic               s0_v;
  logic [P_NBITS-1:0] s0_d;
  logic               acc, emit;

  // Ready chain: a stage can load if it, or any stage below it, is empty, or if the sink
  // is ready.
  always_comb begin
    logic r;
    r = out_ready;
    for (int i = P_DEPTH - 1; i >= 0; i--) begin
      r      = r || !v_q[i];
      rdy[i] = r;
    end
  end

`ifdef ELASTIC_PIPE_SKID_EN
  logic               sv_q, sv_d;
  logic [P_NBITS-1:0] sd_q, sd_d;

  assign in_ready = !sv_q;

  // Stage-0 source selection and skid update. A held skid word has priority over new input.
  always_comb begin
    s0_v = sv_q ? 1'b1 : in_valid;
    s0_d = sv_q ? sd_q : in_data;
    sv_d = sv_q;
    sd_d = sd_q;
    if (sv_q) begin
      if (rdy[0]) sv_d = 1'b0;
    end else if (in_valid && !rdy[0]) begin
      sv_d = 1'b1;
      sd_d = in_data;
    end
    if (flush) begin
      sv_d = 1'b0;
      sd_d = '0;
    end
  end

  // Skid register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sv_q <= 1'b0;
      sd_q <= '0;
    end else begin
      sv_q <= sv_d;
      sd_q <= sd_d;
    end
  end
`else
  assign in_ready = rdy[0];

  // Stage 0 loads directly from the input.
  always_comb begin
    s0_v = in_valid;
    s0_d = in_data;
  end
`endif

  assign acc       = in_valid && in_ready;
  assign emit      = out_valid && out_ready;
  assign out_valid = v_q[P_DEPTH-1];
  assign out_data  = d_q[P_DEPTH-1];
  assign count     = count_q;

  // Next state for the stages and the counter. Data holds when the source is invalid,
  // which saves toggles. Flush overrides every other rule.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (rdy[0]) begin
      v_d[0] = s0_v;
      if (s0_v) d_d[0] = s0_d;
    end
    for (int i = 1; i < P_DEPTH; i++) begin
      if (rdy[i]) begin
        v_d[i] = v_q[i-1];
        if (v_q[i-1]) d_d[i] = d_q[i-1];
      end
    end
    count_d = count_q + P_CNTW'(acc) - P_CNTW'(emit);
    if (flush) begin
      v_d     = '0;
      count_d = '0;
      for (int i = 0; i < P_DEPTH; i++) d_d[i] = '0;
    end
  end

  // Stage and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < P_DEPTH; i++) d_q[i] <= '0;
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      for (int i = 0; i < P_DEPTH; i++) d_q[i] <= d_d[i];
    end
  end

endmodule

// File: tb/tb_elastic_pipe.sv
// Directed self-checking bench for elastic_pipe (P_NBITS=32, P_DEPTH=3).
// Inputs change 1 ns after each rising edge. Outputs are sampled 1 ns later.
module tb_elastic_pipe;
  localparam int unsigned NB = 32;
  localparam int unsigned DP = 3;
  localparam int unsigned CW = $clog2(DP + 2);
`ifdef ELASTIC_PIPE_SKID_EN
  localparam int unsigned CAP = DP + 1;
`else
  localparam int unsigned CAP = DP;
`endif

  logic          clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [NB-1:0] in_data, out_data;
  logic [CW-1:0] count;
  int            n_tests, n_fail, nacc;
  logic          rdy_s;

  elastic_pipe #(.P_NBITS(NB), .P_DEPTH(DP)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1);

    // Streaming
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    in_data = 32'h11; tick();
    check("str_lat1", out_valid, 0);
    in_data = 32'h22; tick();
    check("str_lat2", out_valid, 0);
    in_data = 32'h33; tick();
    in_valid = 1'b0;
    check("str_v0", out_valid, 1);
    check("str_d0", out_data, 32'h11);
    check("str_peak", count, 3);
    tick();
    check("str_d1", out_data, 32'h22);
    check("str_v1", out_valid, 1);
    tick();
    check("str_d2", out_data, 32'h33);
    check("str_v2", out_valid, 1);
    tick();
    check("str_end_v", out_valid, 0);
    check("str_end_cnt", count, 0);

    // Fill and stall
    do_reset();
    nacc = 0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_data  = 32'h100 + nacc;
      #1;
      check("fill_rdy", in_ready, (nacc < CAP) ? 1 : 0);
      rdy_s = in_ready;
      tick();
      if (rdy_s) nacc++;
    end
    check("fill_acc", nacc, CAP);
    check("fill_cnt", count, CAP);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < int'(CAP); k++) begin
      #1;
      check("drain_v", out_valid, 1);
      check("drain_d", out_data, 32'h100 + k);
      tick();
    end
    check("drain_end_v", out_valid, 0);
    check("drain_end_cnt", count, 0);

    // Bubble collapse
    do_reset();
    in_valid = 1'b1; in_data = 32'hA5; tick();
    in_valid = 1'b0; tick(); tick(); tick();
    check("bub_v", out_valid, 1);
    in_valid = 1'b1; in_data = 32'h5A; tick();
    in_valid = 1'b0; tick();
    check("bub_cnt", count, 2);
    check("bub_d0", out_data, 32'hA5);
    out_ready = 1'b1; tick();
    check("bub_v1", out_valid, 1);
    check("bub_d1", out_data, 32'h5A);
    tick();
    check("bub_end", out_valid, 0);

    // Flush with a full chain and a word offered in the flush cycle
    do_reset();
    for (int k = 0; k < int'(CAP); k++) begin
      in_valid = 1'b1; in_data = 32'h200 + k; tick();
    end
    check("fl_full_cnt", count, CAP);
    in_valid = 1'b1; in_data = 32'hBAD; flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_v", out_valid, 0);
    check("fl_cnt", count, 0);
    check("fl_d", out_data, 0);
    out_ready = 1'b1;
    tick(); tick(); tick(); tick();
    check("fl_absent_v", out_valid, 0);
    check("fl_absent_cnt", count, 0);

    // Simultaneous accept and emit with a full chain
    do_reset();
    for (int k = 0; k < int'(DP); k++) begin
      in_valid = 1'b1; in_data = 32'h61 + k; tick();
    end
    check("sim_d0", out_data, 32'h61);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h64;
    #1;
    check("sim_rdy", in_ready, 1);
    check("sim_v", out_valid, 1);
    tick();
    in_valid = 1'b0;
    check("sim_cnt", count, DP);
    check("sim_d1", out_data, 32'h62);
    tick();
    check("sim_d2", out_data, 32'h63);
    tick();
    check("sim_d3", out_data, 32'h64);
    check("sim_v3", out_valid, 1);
    tick();
    check("sim_end", out_valid, 0);

    // Asynchronous reset in mid-stream
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    in_data = 32'hC1; tick();
    in_data = 32'hC2; tick();
    in_data = 32'hC3; tick();
    check("ar_pre_v", out_valid, 1);
    #3;
    rst = 1'b1;
    #1;
    check("ar_v", out_valid, 0);
    check("ar_cnt", count, 0);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    in_valid = 1'b1; in_data = 32'hDEADBEEF; tick();
    in_valid = 1'b0;
    check("ar_lat1", out_valid, 0);
    tick();
    check("ar_lat2", out_valid, 0);
    tick();
    check("ar_new_v", out_valid, 1);
    check("ar_new_d", out_data, 32'hDEADBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/elastic_pipe.md
# elastic_pipe

Parametrised elastic pipeline register chain with valid/ready handshake, synchronous flush and an occupancy count. It replaces hand-chained enable/clear flops between CPU pipeline stages (IF→ID→EX→MEM→WB) and in memory-side paths where back-pressure must stall without losing or duplicating data. Each of `P_DEPTH` stages holds one word. A stage advances whenever it is empty or its downstream neighbour advances, so the chain sustains full throughput.

## Interface
- `P_NBITS`, default 32: payload width, ≥1.
- `P_DEPTH`, default 2: number of register stages, ≥1.
- `P_CNTW`, default `$clog2(P_DEPTH+2)`: occupancy counter width. It is sized for the skid option.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `flush` input 1: synchronous clear of all held entries.
- `in_valid` input 1: upstream word present.
- `in_ready` output 1: block accepts this cycle.
- `in_data` input `P_NBITS`: upstream payload.
- `out_valid` output 1: stage `P_DEPTH-1` holds a word.
- `out_ready` input 1: downstream accepts.
- `out_data` output `P_NBITS`: payload of the last stage.
- `count` output `P_CNTW`: number of valid entries held, including the skid entry if present.

## Operation
- Per stage i (0…P_DEPTH-1) there are registers `v[i]` and `d[i]`.
- `rdy[P_DEPTH] = out_ready`.
- `rdy[i] = !v[i] || rdy[i+1]`.
- `out_valid = v[P_DEPTH-1]` and `out_data = d[P_DEPTH-1]`.
- Accept handshake: `in_valid && in_ready`. Emit handshake: `out_valid && out_ready`.
- When `rdy[i]` is high:
  - `v[i] <= src_valid`.
  - `d[i] <= src_data` only if `src_valid`. Otherwise `d[i]` holds its value, which saves toggles.
  - For stage 0 the source is the input (or the skid entry). For stage i>0 the source is stage i-1.
- When `rdy[i]` is low, `v[i]` and `d[i]` hold. This is a stall.
- Bubbles collapse: an empty stage loads even while a downstream stage stalls.
- `flush` has priority over every other next-state rule.
  - All `v` are cleared and all `d` are set to 0 on the next edge.
  - An accept in the flush cycle is discarded.
  - An emit in the flush cycle still counts as delivered to downstream.
  - `in_ready` is not gated by `flush`.
- `count` increments on accept and decrements on emit. Both in the same cycle leaves it unchanged. `flush` sets it to 0.
- Data is never dropped or duplicated outside `flush`.

## Timing
- Reset values: all `v`=0, `d`=0, `count`=0, `out_valid`=0, `out_data`=0.
- In the base configuration `in_ready`=1 during reset.
- Latency: a word accepted at edge N with an unstalled chain appears on `out_valid` after edge N+P_DEPTH-1. Equivalently, it is visible in the P_DEPTH-th cycle after acceptance.
- Throughput is one word per cycle when `out_ready` is held at 1.
- In the base configuration `in_ready` is combinational from `out_ready` through the `rdy` chain.
- Reset mid-operation clears everything immediately (asynchronous). Deassertion is synchronous to `clk` by convention of the surrounding design.
- Full condition: all `v`=1 and `out_ready`=0 gives `in_ready`=0.
- Simultaneous full and `out_ready`=1: `in_ready`=1 and the chain shifts.

## Configuration
- Macro `ELASTIC_PIPE_SKID_EN` adds a one-entry input skid buffer (`sv`, `sd`).
- With the macro defined:
  - `in_ready = !sv` is registered, which breaks the combinational ready path.
  - An accepted word with `rdy[0]`=0 is written into the skid.
  - While `sv`=1, stage 0 loads from the skid (when `rdy[0]`), and then `sv` clears.
  - Capacity is P_DEPTH+1.
  - `flush` clears `sv` and sets `sd`=0.
  - Reset: `sv`=0 and `in_ready`=1.
- Without the macro the skid logic is absent, capacity is P_DEPTH, and `count` never exceeds P_DEPTH.

## Test plan
- **Streaming.** P_NBITS=32, P_DEPTH=3, `out_ready`=1. Drive 0x11,0x22,0x33 on consecutive cycles. Required: they emerge in order on consecutive cycles, the first 3 cycles after acceptance, and `count` peaks at 3.
- **Fill and stall.** `out_ready`=0 while driving 5 words. Required:
  - Base: `in_ready` falls after 3 accepts and `count`=3.
  - Skid: `in_ready` falls after 4 accepts and `count`=4.
  - Raising `out_ready` drains the words in order with no loss.
- **Bubble collapse.** Accept one word (0xA5) with `out_ready`=0. Wait, then accept 0x5A. Required: both are adjacent in the last two stages and `count`=2.
- **Flush.** Chain full and `in_valid`=1 in the flush cycle. Required: the next cycle has `out_valid`=0, `count`=0 and `out_data`=0. The word offered in the flush cycle is absent afterwards.
- **Simultaneous.** Full chain, `out_ready`=1, `in_valid`=1. Required: one emit and one accept in the same cycle, and `count` stays at P_DEPTH.
- **Async reset.** Assert `rst` mid-stream between clock edges. Required: `out_valid`=0 and `count`=0 immediately. After release, a new word 0xDEADBEEF passes with the normal latency.
